// File: rtl/myproject_dense_pkg.sv
// Shared definitions for the dense-layer accumulate stages: default widths,
// FSM state encoding and an elaboration-time ceil(log2) helper.
package myproject_dense_pkg;

  localparam int PROD_WIDTH_DEF = 18;
  localparam int OUT_WIDTH_DEF  = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'sd1 <<< i) < n) ? (i + 1) : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/myproject_round_sat.sv
// Combinational round-half-up and saturate of an accumulator sum into the
// signed layer output format.
module myproject_round_sat
  import myproject_dense_pkg::*;
#(
  parameter int ACC_WIDTH = 26,
  parameter int SHIFT     = 4,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic [ACC_WIDTH-1:0] sum_i,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat
);

  localparam int W = ACC_WIDTH + 1;
  localparam logic signed [W-1:0] MAX_S = {{(W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_S = {{(W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [W-1:0] ext_s;
  logic signed [W-1:0] rnd_s;

  // One guard bit so adding the rounding half can never wrap.
  assign ext_s = $signed({sum_i[ACC_WIDTH-1], sum_i});

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [W-1:0] HALF_S = {{(W-1){1'b0}}, 1'b1} <<< (SHIFT - 1);
      assign rnd_s = (ext_s + HALF_S) >>> SHIFT;
    end else begin : g_pass
      assign rnd_s = ext_s;
    end
  endgenerate

  always_comb begin
    out_data = rnd_s[OUT_WIDTH-1:0];
    out_sat  = 1'b0;
    if (rnd_s > MAX_S) begin
      out_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      out_sat  = 1'b1;
    end else if (rnd_s < MIN_S) begin
      out_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      out_sat  = 1'b1;
    end else begin
      out_sat  = 1'b0;
    end
  end

endmodule

// File: rtl/myproject_dense_accum_18s.sv
// Dense-layer accumulator: sums N_IN signed products plus a bias per neuron,
// rounds/saturates the result and offers it on a valid/ready output.
module myproject_dense_accum_18s
  import myproject_dense_pkg::*;
#(
  parameter int PROD_WIDTH = PROD_WIDTH_DEF,
  parameter int N_IN       = 16,
  parameter int BIAS_WIDTH = 16,
  parameter int ACC_WIDTH  = 26,
  parameter int SHIFT      = 4,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [PROD_WIDTH-1:0] prod_data,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  input  logic [BIAS_WIDTH-1:0] bias,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sat
);

  localparam int CNT_LOG = clog2(N_IN);
  localparam int CNT_W   = (CNT_LOG > 0) ? CNT_LOG : 1;
  localparam int IN_MAX  = (PROD_WIDTH > BIAS_WIDTH) ? PROD_WIDTH : BIAS_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  generate
    if (N_IN < 1) begin : g_nin_err
      $error("myproject_dense_accum_18s: N_IN must be at least 1");
    end
    if (ACC_WIDTH < IN_MAX + CNT_LOG + 1) begin : g_acc_err
      $error("myproject_dense_accum_18s: ACC_WIDTH too narrow for N_IN products plus bias");
    end
  endgenerate

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_sat_q, out_sat_d;

  logic                   prod_ready_s;
  logic                   beat_s;
  logic [ACC_WIDTH-1:0]   bias_ext_s;
  logic [ACC_WIDTH-1:0]   prod_ext_s;
  logic [ACC_WIDTH-1:0]   sum_s;
  logic [OUT_WIDTH-1:0]   rs_data_s;
  logic                   rs_sat_s;

  assign bias_ext_s = {{(ACC_WIDTH-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias};
  assign prod_ext_s = {{(ACC_WIDTH-PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
  // The first beat of each vector starts from the bias instead of the old sum.
  assign sum_s      = ((cnt_q == CNT_ZERO) ? bias_ext_s : acc_q) + prod_ext_s;

  myproject_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .SHIFT     (SHIFT),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_round_sat (
    .sum_i    (sum_s),
    .out_data (rs_data_s),
    .out_sat  (rs_sat_s)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_sat_d    = out_sat_q;
    prod_ready_s = 1'b1;

    case (state_q)
      ACCUM: begin
        prod_ready_s = 1'b1;
        out_valid_d  = 1'b0;
      end
      HOLD: begin
        // Accepting a new beat while the result drains keeps the stream bubble-free.
        prod_ready_s = out_ready;
        if (out_ready) begin
          state_d     = ACCUM;
          out_valid_d = 1'b0;
        end else begin
          state_d     = HOLD;
        end
      end
      default: begin
        prod_ready_s = 1'b0;
        state_d      = ACCUM;
        out_valid_d  = 1'b0;
      end
    endcase

    beat_s = prod_valid && prod_ready_s;

    if (beat_s) begin
      acc_d = sum_s;
      if (cnt_q == CNT_LAST) begin
        cnt_d       = CNT_ZERO;
        out_data_d  = rs_data_s;
        out_sat_d   = rs_sat_s;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end else begin
        cnt_d       = cnt_q + CNT_ONE;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= ACCUM;
      cnt_q       <= CNT_ZERO;
      acc_q       <= {ACC_WIDTH{1'b0}};
      out_data_q  <= {OUT_WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign prod_ready = prod_ready_s;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_sat    = out_sat_q;

endmodule

// File: tb/tb_myproject_dense_accum_18s.sv
// Directed bench: three accumulator configurations share one input stream;
// each phase checks the instance whose parameters it targets.
module tb_myproject_dense_accum_18s;

  logic        ap_clk;
  logic        ap_rst;
  logic [17:0] prod_data;
  logic        prod_valid;
  logic [15:0] bias;
  logic        out_ready;

  logic               prod_ready_a, out_valid_a, out_sat_a;
  logic signed [15:0] out_data_a;
  logic               prod_ready_b, out_valid_b, out_sat_b;
  logic signed [15:0] out_data_b;
  logic               prod_ready_c, out_valid_c, out_sat_c;
  logic signed [15:0] out_data_c;

  int n_pass;
  int n_total;

  // N_IN=4, no fractional shift
  myproject_dense_accum_18s #(.N_IN(4), .SHIFT(0)) dut_a (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .prod_data(prod_data), .prod_valid(prod_valid),
    .prod_ready(prod_ready_a), .bias(bias), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_sat(out_sat_a)
  );

  // defaults: N_IN=16, SHIFT=4
  myproject_dense_accum_18s dut_b (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .prod_data(prod_data), .prod_valid(prod_valid),
    .prod_ready(prod_ready_b), .bias(bias), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_sat(out_sat_b)
  );

  // N_IN=16, no fractional shift
  myproject_dense_accum_18s #(.SHIFT(0)) dut_c (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .prod_data(prod_data), .prod_valid(prod_valid),
    .prod_ready(prod_ready_c), .bias(bias), .out_data(out_data_c), .out_valid(out_valid_c),
    .out_ready(out_ready), .out_sat(out_sat_c)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    prod_valid = 1'b0;
    ap_rst     = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst     = 1'b0;
  endtask

  task automatic beat(input int v);
    prod_data  = v[17:0];
    prod_valid = 1'b1;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic vec(input int n, input int first, input int rest);
    for (int i = 0; i < n; i++) begin
      beat((i == 0) ? first : rest);
    end
    prod_valid = 1'b0;
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    prod_data  = 18'd0;
    prod_valid = 1'b0;
    bias       = 16'd0;
    out_ready  = 1'b1;
    ap_rst     = 1'b1;

    // reset state
    do_reset();
    check("rst_valid", out_valid_a, 0);
    check("rst_data", out_data_a, 0);
    check("rst_sat", out_sat_a, 0);
    check("rst_ready", prod_ready_a, 1);

    // basic sum with bias, latency
    bias = 16'd5;
    beat(1); beat(2); beat(3);
    check("t1_valid_early", out_valid_a, 0);
    beat(4);
    prod_valid = 1'b0;
    check("t1_valid", out_valid_a, 1);
    check("t1_data", out_data_a, 15);
    check("t1_sat", out_sat_a, 0);
    @(posedge ap_clk);
    #1;
    check("t1_valid_drop", out_valid_a, 0);

    // rounding with SHIFT=4
    do_reset();
    bias = 16'd0;
    vec(16, 24, 0);
    check("t2_p24", out_data_b, 2);
    check("t2_p24_sat", out_sat_b, 0);
    vec(16, -24, 0);
    check("t2_m24", out_data_b, -1);
    vec(16, 8, 0);
    check("t2_p8", out_data_b, 1);
    vec(16, 7, 0);
    check("t2_p7", out_data_b, 0);

    // saturation with SHIFT=0, N_IN=16
    do_reset();
    vec(16, 131071, 131071);
    check("t3_max_data", out_data_c, 32767);
    check("t3_max_sat", out_sat_c, 1);
    vec(16, -131072, -131072);
    check("t3_min_data", out_data_c, -32768);
    check("t3_min_sat", out_sat_c, 1);
    bias = 16'h7FFF;
    vec(16, 0, 0);
    check("t3_edge_hi_data", out_data_c, 32767);
    check("t3_edge_hi_sat", out_sat_c, 0);
    vec(16, 1, 0);
    check("t3_over_hi_data", out_data_c, 32767);
    check("t3_over_hi_sat", out_sat_c, 1);
    bias = 16'h8000;
    vec(16, 0, 0);
    check("t3_edge_lo_data", out_data_c, -32768);
    check("t3_edge_lo_sat", out_sat_c, 0);
    vec(16, -1, 0);
    check("t3_over_lo_data", out_data_c, -32768);
    check("t3_over_lo_sat", out_sat_c, 1);

    // backpressure in HOLD
    do_reset();
    bias      = 16'd0;
    out_ready = 1'b0;
    beat(10); beat(20); beat(30); beat(40);
    prod_data = 18'd7;
    check("t4_valid", out_valid_a, 1);
    check("t4_ready_low", prod_ready_a, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge ap_clk);
      #1;
      check("t4_stall_ready", prod_ready_a, 0);
      check("t4_stall_data", out_data_a, 100);
      check("t4_stall_valid", out_valid_a, 1);
    end
    out_ready = 1'b1;
    #1;
    check("t4_ready_follow", prod_ready_a, 1);
    @(posedge ap_clk);
    #1;
    check("t4_released", out_valid_a, 0);
    beat(7); beat(7); beat(7);
    prod_valid = 1'b0;
    check("t4_next_valid", out_valid_a, 1);
    check("t4_next_data", out_data_a, 28);

    // streaming: three back-to-back vectors, bias=1
    do_reset();
    bias = 16'd1;
    for (int j = 1; j <= 12; j++) begin
      beat(j);
      check("t5_valid", out_valid_a, ((j % 4) == 0) ? 1 : 0);
      if ((j % 4) == 0) begin
        check("t5_data", out_data_a, 1 + (j - 3) + (j - 2) + (j - 1) + j);
      end
    end
    prod_valid = 1'b0;
    @(posedge ap_clk);
    #1;

    // reset mid-vector discards partial sum
    bias = 16'd0;
    beat(50); beat(50);
    prod_valid = 1'b0;
    ap_rst = 1'b1;
    #2;
    check("t6_rst_data", out_data_a, 0);
    check("t6_rst_valid", out_valid_a, 0);
    check("t6_rst_sat", out_sat_a, 0);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    vec(4, 1, 1);
    check("t6_valid", out_valid_a, 1);
    check("t6_data", out_data_a, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
